complex_gain_scaler: RTL
========================

Name: complex_gain_scaler

Overview:
Pipelined, parametrised complex-sample-by-gain multiplier for the FFT output path of the receiver.
- Scales each complex bin (real/imag) by a run-time programmable gain.
- Applies fixed-point rounding and saturation.
- Carries samples over a valid/ready stream handshake with back-pressure.
- Counts saturation events for gain-control firmware.
- Sits between the FFT core and the magnitude/detection stage.

Parameters:
DATA_W, 8, signed width of input and output real/imag samples
GAIN_W, 8, signed width of gain word
FRAC_BITS, 0, fractional bits of gain; product is rounded then shifted right by this amount (0 to GAIN_W-1)
CNT_W, 16, width of saturation event counter

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
gain_load  in  1  pulse: capture gain_in
gain_in  in  GAIN_W  signed gain value
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
in_re  in  DATA_W  signed real part
in_im  in  DATA_W  signed imaginary part
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts output
out_re  out  DATA_W  scaled, rounded, saturated real part
out_im  out  DATA_W  scaled, rounded, saturated imaginary part
sat_flag  out  1  sticky: any saturation since reset/clear
sat_count  out  CNT_W  number of output samples that saturated, stops at all-ones
sat_clear  in  1  pulse: clear sat_flag and sat_count

Behaviour:
- Clock and reset: single clock, clk. reset is asynchronous, active-high.
- Reset values:
  - out_valid=0, out_re=0, out_im=0
  - sat_flag=0, sat_count=0
  - gain register=1<<FRAC_BITS (unity)
  - all pipeline valid bits=0
  - in_ready=1 once reset deasserts.
- Pipeline:
  - Stage 1 registers the full products re*gain and im*gain, each DATA_W+GAIN_W bits, signed.
  - Stage 2 registers the rounded/saturated result onto out_re/out_im, with its valid onto out_valid.
  - Latency is 2 cycles from an accepted input to out_valid when not stalled. Throughput is 1 sample/cycle.
- Handshake:
  - advance = !out_valid || out_ready. The whole pipeline moves only when advance=1.
  - in_ready = advance.
  - An input transfer occurs on in_valid && in_ready. An output transfer occurs on out_valid && out_ready.
  - When stalled, out_re/out_im/out_valid hold stable. No sample is lost or duplicated.
  - Bubbles (in_valid=0 while advancing) propagate as invalid stages.
- Gain:
  - gain_load captures gain_in on the same edge.
  - A sample takes the gain in effect on the edge it is accepted. A load on that same edge applies to that sample (new value wins).
  - Samples already in the pipeline keep the gain they were multiplied with.
- Rounding:
  - If FRAC_BITS>0, add 1<<(FRAC_BITS-1) to the product, then arithmetic shift right by FRAC_BITS. This is round half toward +inf.
  - If FRAC_BITS=0, no rounding and no shift.
- Saturation:
  - Clamp the shifted value to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - A sample counts as saturated if either part clamps.
  - On a saturated sample entering stage 2: sat_flag is set and sat_count increments by 1, holding at all-ones.
- sat_clear: clears sat_flag and sat_count on the edge. If a saturating sample lands on the same edge, the result is sat_flag=1 and sat_count=1.
- Special case: the gain minimum (-2^(GAIN_W-1)) times the data minimum must not overflow the internal product width.

Optional Feature:
COMPLEX_GAIN_EN
- Defined:
  - Adds input port gain_im_in (GAIN_W), captured by gain_load together with gain_in.
  - Stage 1 computes the full complex product: re = a*gr - b*gi, im = a*gi + b*gr, at width DATA_W+GAIN_W+1.
  - gain_im resets to 0. Latency is unchanged.
- Undefined: real-gain-only datapath as above, and the port is absent.

Decomposition:
- Shared package cgs_pkg holds:
  - the product-width constant function
  - the saturation min/max constant functions for a given width
  - the reset unity-gain constant.
- One sub-module, round_sat, is natural:
  - combinational, parametrised by IN_W/OUT_W/FRAC_BITS
  - outputs the rounded value and a clamp flag
  - instantiated once per real/imag lane.

Test Plan:
All scenarios use DATA_W=8, GAIN_W=8, FRAC_BITS=4 unless noted.
1. Reset, then in (16,-16), no gain load -> out (16,-16) 2 cycles later, sat_count=0.
2. Load gain 32 (2.0), in (16,-16) -> out (32,-32). Also in (3,-3) with gain 8 (0.5) -> out (2,-1) (rounding half-up).
3. Gain 64, in (100,-100) -> out (127,-128), sat_flag=1, sat_count=1. Then sat_clear -> both 0.
4. Stream 6 samples with out_ready low for cycles 2-6 -> in_ready low during stall, outputs held stable, all 6 emerge in order with no loss or duplication.
5. gain_load of 48 on the same edge the 3rd of 5 streamed samples is accepted -> samples 1-2 use the old gain, samples 3-5 use 48.
6. Assert reset while 2 samples are in flight -> out_valid drops immediately, no stale output after release, gain returns to unity.

Source files
------------

// File: rtl/cgs_pkg.sv
// Shared constants and width helpers for complex_gain_scaler.
// COMPLEX_GAIN_EN selects the complex-gain datapath.
package cgs_pkg;

`ifdef COMPLEX_GAIN_EN
  localparam bit CPLX_EN = 1'b1;
`else
  localparam bit CPLX_EN = 1'b0;
`endif

  // min*min needs the full sum of widths; complex adds a carry bit
  function automatic int prod_w(input int dw, input int gw,
                                input bit cplx);
    return dw + gw + (cplx ? 1 : 0);
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  function automatic longint unity_gain(input int frac);
    return longint'(1) <<< frac;
  endfunction

endpackage

// File: rtl/round_sat.sv
// Round-half-up, arithmetic shift and clamp of one product lane.
// Purely combinational; clamp_o flags a saturated lane.
module round_sat
  import cgs_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 8,
  parameter int FRAC_BITS = 0
) (
  input  logic signed [IN_W-1:0]  din_i,
  output logic signed [OUT_W-1:0] dout_o,
  output logic                    clamp_o
);

  localparam int EXT_W = IN_W + 1;
  localparam logic signed [EXT_W-1:0] HALF =
    EXT_W'((1 << FRAC_BITS) >> 1);
  localparam logic signed [EXT_W-1:0] MAXV =
    EXT_W'(sat_max(OUT_W));
  localparam logic signed [EXT_W-1:0] MINV =
    EXT_W'(sat_min(OUT_W));

  logic signed [EXT_W-1:0] rnd;
  logic signed [EXT_W-1:0] shf;

  // extra bit keeps the rounding add from wrapping
  assign rnd = {din_i[IN_W-1], din_i} + HALF;
  assign shf = rnd >>> FRAC_BITS;

  always_comb begin
    dout_o  = shf[OUT_W-1:0];
    clamp_o = 1'b0;
    unique case (1'b1)
      (shf > MAXV): begin
        dout_o  = MAXV[OUT_W-1:0];
        clamp_o = 1'b1;
      end
      (shf < MINV): begin
        dout_o  = MINV[OUT_W-1:0];
        clamp_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/complex_gain_scaler.sv
// Two-stage gain multiplier with round/saturate and stream handshake.
// Define COMPLEX_GAIN_EN for a complex gain (adds gain_im_in).
module complex_gain_scaler
  import cgs_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int GAIN_W    = 8,
  parameter int FRAC_BITS = 0,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     gain_load,
  input  logic signed [GAIN_W-1:0] gain_in,
`ifdef COMPLEX_GAIN_EN
  input  logic signed [GAIN_W-1:0] gain_im_in,
`endif
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic                     sat_flag,
  output logic [CNT_W-1:0]         sat_count,
  input  logic                     sat_clear
);

  localparam int PW = prod_w(DATA_W, GAIN_W, CPLX_EN);
  localparam logic signed [GAIN_W-1:0] UNITY =
    GAIN_W'(unity_gain(FRAC_BITS));

  logic                     advance;
  logic signed [GAIN_W-1:0] gain_q;
  logic signed [GAIN_W-1:0] gain_eff;
  logic signed [PW-1:0]     a, b, gr;
  logic signed [PW-1:0]     prod_re, prod_im;

  logic                     s1_valid_q;
  logic signed [PW-1:0]     s1_re_q, s1_im_q;

  logic signed [DATA_W-1:0] rs_re, rs_im;
  logic                     clamp_re, clamp_im;

  logic                     out_valid_q;
  logic signed [DATA_W-1:0] out_re_q, out_im_q;

  logic                     sat_hit;
  logic                     sat_flag_d, sat_flag_q;
  logic [CNT_W-1:0]         sat_cnt_d, sat_cnt_q;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // a load on the accepting edge applies to that sample
  assign gain_eff = gain_load ? gain_in : gain_q;

  assign a  = PW'(in_re);
  assign b  = PW'(in_im);
  assign gr = PW'(gain_eff);

`ifdef COMPLEX_GAIN_EN
  logic signed [GAIN_W-1:0] gain_im_q;
  logic signed [GAIN_W-1:0] gain_im_eff;
  logic signed [PW-1:0]     gi;

  assign gain_im_eff = gain_load ? gain_im_in : gain_im_q;
  assign gi          = PW'(gain_im_eff);
  assign prod_re     = (a * gr) - (b * gi);
  assign prod_im     = (a * gi) + (b * gr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gain_im_q <= '0;
    end else if (gain_load) begin
      gain_im_q <= gain_im_in;
    end
  end
`else
  assign prod_re = a * gr;
  assign prod_im = b * gr;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gain_q <= UNITY;
    end else if (gain_load) begin
      gain_q <= gain_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_re_q <= prod_re;
        s1_im_q <= prod_im;
      end
    end
  end

  round_sat #(
    .IN_W     (PW),
    .OUT_W    (DATA_W),
    .FRAC_BITS(FRAC_BITS)
  ) u_rs_re (
    .din_i  (s1_re_q),
    .dout_o (rs_re),
    .clamp_o(clamp_re)
  );

  round_sat #(
    .IN_W     (PW),
    .OUT_W    (DATA_W),
    .FRAC_BITS(FRAC_BITS)
  ) u_rs_im (
    .din_i  (s1_im_q),
    .dout_o (rs_im),
    .clamp_o(clamp_im)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else if (advance) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_re_q <= rs_re;
        out_im_q <= rs_im;
      end
    end
  end

  assign sat_hit = advance && s1_valid_q && (clamp_re || clamp_im);

  // clear first so a saturation on the same edge still counts once
  always_comb begin
    sat_flag_d = sat_flag_q;
    sat_cnt_d  = sat_cnt_q;
    if (sat_clear) begin
      sat_flag_d = 1'b0;
      sat_cnt_d  = '0;
    end
    if (sat_hit) begin
      sat_flag_d = 1'b1;
      if (sat_cnt_d != '1) begin
        sat_cnt_d = sat_cnt_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_flag_q <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      sat_flag_q <= sat_flag_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign sat_flag  = sat_flag_q;
  assign sat_count = sat_cnt_q;

endmodule
